// File: rtl/qdr_req_arbiter.sv
// ============================================================================
// qdr_req_arbiter
// ----------------------------------------------------------------------------
// Round-robin arbiter that shares one QDR SRAM user command port between the
// packet datapath (requester 0) and the register/host path (requester 1).
// Reads return in order. A tag FIFO records the owner of every outstanding
// read so that each return is routed back to the requester that issued it.
// A drain handshake quiesces the port before the controller switches banks.
//
// Ports
//   axi_aclk, axi_reset            clock, synchronous active-high reset
//   req_valid_N / req_ready_N      command handshake per requester
//   req_wr_N, req_addr_N, req_wdata_N   command fields per requester
//   rsp_valid_N, rsp_data_N        read return per requester (no backpressure)
//   mem_cmd_*                      command to the QDR controller
//   mem_rd_valid, mem_rd_data      in-order read return from the controller
//   drain_req / drain_done         quiesce request (level) / quiesced status
//   rsp_err                        sticky: read return with no read outstanding
//
// Build option
//   QDR_ARB_STATS_EN  adds 32-bit counters stat_grant_0, stat_grant_1 and
//                     stat_stall (cycles with mem_cmd_valid & ~mem_cmd_ready).
//
// TAG_DEPTH must be a power of two and at least 2.
// ============================================================================
module qdr_req_arbiter #(
    parameter int ADDR_WIDTH = 19,
    parameter int DATA_WIDTH = 144,
    parameter int TAG_DEPTH  = 16
) (
    input  logic                  axi_aclk,
    input  logic                  axi_reset,

    input  logic                  req_valid_0,
    output logic                  req_ready_0,
    input  logic                  req_wr_0,
    input  logic [ADDR_WIDTH-1:0] req_addr_0,
    input  logic [DATA_WIDTH-1:0] req_wdata_0,

    input  logic                  req_valid_1,
    output logic                  req_ready_1,
    input  logic                  req_wr_1,
    input  logic [ADDR_WIDTH-1:0] req_addr_1,
    input  logic [DATA_WIDTH-1:0] req_wdata_1,

    output logic                  rsp_valid_0,
    output logic [DATA_WIDTH-1:0] rsp_data_0,
    output logic                  rsp_valid_1,
    output logic [DATA_WIDTH-1:0] rsp_data_1,

    output logic                  mem_cmd_valid,
    input  logic                  mem_cmd_ready,
    output logic                  mem_cmd_wr,
    output logic [ADDR_WIDTH-1:0] mem_cmd_addr,
    output logic [DATA_WIDTH-1:0] mem_cmd_wdata,
    input  logic                  mem_rd_valid,
    input  logic [DATA_WIDTH-1:0] mem_rd_data,

    input  logic                  drain_req,
    output logic                  drain_done,
    output logic                  rsp_err
`ifdef QDR_ARB_STATS_EN
    ,
    output logic [31:0]           stat_grant_0,
    output logic [31:0]           stat_grant_1,
    output logic [31:0]           stat_stall
`endif
);

    localparam int PTR_W = $clog2(TAG_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(TAG_DEPTH);

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DRAIN  = 2'd1,
        HALTED = 2'd2
    } state_t;

    state_t             state;
    logic               last;          // most recent grantee
    logic [CNT_W-1:0]   count;         // outstanding reads
    logic [CNT_W-1:0]   count_nxt;
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic               tag_mem [TAG_DEPTH];

    logic run_now;
    logic rd_ok;
    logic elig_0, elig_1;
    logic gnt_0, gnt_1;
    logic handshake;
    logic push, pop;
    logic pop_id;

    // ------------------------------------------------------------------------
    // Eligibility and grant
    // ------------------------------------------------------------------------
    // drain_req bypasses the state register so that no command issues in the
    // very cycle drain is requested. Reset gates grants so every output is 0
    // while axi_reset is held.
    assign run_now = (state == RUN) && !drain_req && !axi_reset;
    assign rd_ok   = (count < CNT_FULL);

    // A full tag FIFO blocks only reads; writes keep flowing.
    assign elig_0 = req_valid_0 && run_now && (req_wr_0 || rd_ok);
    assign elig_1 = req_valid_1 && run_now && (req_wr_1 || rd_ok);

    // The requester that was not granted last has priority under contention.
    assign gnt_0 = elig_0 && (!elig_1 || last);
    assign gnt_1 = elig_1 && (!elig_0 || !last);

    assign req_ready_0 = gnt_0 && mem_cmd_ready;
    assign req_ready_1 = gnt_1 && mem_cmd_ready;

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can
        // leave it unassigned and infer a latch.
        mem_cmd_valid = 1'b0;
        mem_cmd_wr    = 1'b0;
        mem_cmd_addr  = '0;
        mem_cmd_wdata = '0;
        if (gnt_0) begin
            mem_cmd_valid = 1'b1;
            mem_cmd_wr    = req_wr_0;
            mem_cmd_addr  = req_addr_0;
            mem_cmd_wdata = req_wdata_0;
        end else if (gnt_1) begin
            mem_cmd_valid = 1'b1;
            mem_cmd_wr    = req_wr_1;
            mem_cmd_addr  = req_addr_1;
            mem_cmd_wdata = req_wdata_1;
        end
    end

    assign handshake = mem_cmd_valid && mem_cmd_ready;

    // ------------------------------------------------------------------------
    // Read tag tracking
    // ------------------------------------------------------------------------
    assign push   = handshake && !mem_cmd_wr;
    assign pop    = mem_rd_valid && (count != '0);
    assign pop_id = tag_mem[rd_ptr];

    always_comb begin
        count_nxt = count;
        case ({push, pop})
            2'b10:   count_nxt = count + 1'b1;
            2'b01:   count_nxt = count - 1'b1;
            default: count_nxt = count;
        endcase
    end

    // NOTE: the tag storage is not reset; the pointers and count define which
    // entries are meaningful, so clearing the array would only cost logic.
    always_ff @(posedge axi_aclk) begin
        if (push) begin
            tag_mem[wr_ptr] <= gnt_1;
        end
    end

    always_ff @(posedge axi_aclk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (axi_reset) begin
            last        <= 1'b1;
            count       <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            rsp_valid_0 <= 1'b0;
            rsp_valid_1 <= 1'b0;
            rsp_data_0  <= '0;
            rsp_data_1  <= '0;
            rsp_err     <= 1'b0;
        end else begin
            count <= count_nxt;
            if (handshake) begin
                last <= gnt_1;
            end
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end

            rsp_valid_0 <= pop && !pop_id;
            rsp_valid_1 <= pop && pop_id;
            if (pop && !pop_id) begin
                rsp_data_0 <= mem_rd_data;
            end
            if (pop && pop_id) begin
                rsp_data_1 <= mem_rd_data;
            end

            // A return with nothing outstanding is dropped and flagged.
            if (mem_rd_valid && (count == '0)) begin
                rsp_err <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Drain state machine
    // ------------------------------------------------------------------------
    // DRAIN looks at the next count so drain_done rises the cycle after the
    // last return lands. No pushes happen in DRAIN, so count_nxt only falls.
    always_ff @(posedge axi_aclk) begin
        if (axi_reset) begin
            state      <= RUN;
            drain_done <= 1'b0;
        end else begin
            case (state)
                RUN: begin
                    drain_done <= 1'b0;
                    if (drain_req) begin
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (!drain_req) begin
                        state      <= RUN;
                        drain_done <= 1'b0;
                    end else if (count_nxt == '0) begin
                        state      <= HALTED;
                        drain_done <= 1'b1;
                    end
                end
                HALTED: begin
                    if (!drain_req) begin
                        state      <= RUN;
                        drain_done <= 1'b0;
                    end else begin
                        drain_done <= 1'b1;
                    end
                end
                default: begin
                    state      <= RUN;
                    drain_done <= 1'b0;
                end
            endcase
        end
    end

`ifdef QDR_ARB_STATS_EN
    // ------------------------------------------------------------------------
    // Statistics (wrap at 2^32)
    // ------------------------------------------------------------------------
    always_ff @(posedge axi_aclk) begin
        if (axi_reset) begin
            stat_grant_0 <= '0;
            stat_grant_1 <= '0;
            stat_stall   <= '0;
        end else begin
            if (req_ready_0) begin
                stat_grant_0 <= stat_grant_0 + 32'd1;
            end
            if (req_ready_1) begin
                stat_grant_1 <= stat_grant_1 + 32'd1;
            end
            if (mem_cmd_valid && !mem_cmd_ready) begin
                stat_stall <= stat_stall + 32'd1;
            end
        end
    end
`endif

endmodule
